if_id_stage: RTL and testbench



---
 rtl/if_id_stage_pkg.sv | 38 +++
 rtl/if_id_stage_program_counter.sv | 42 ++++
 rtl/if_id_stage.sv | 107 ++++++++++
 tb/tb_if_id_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// the NOP encoding, the default reset PC and the PC update priority.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  typedef enum logic [1:0] {
    PC_NORMAL,
    PC_STALL,
    PC_FLUSH
  } pc_op_e;

  // A redirect always wins over a stall request from the hazard unit.
  function automatic pc_op_e pcOpSelect(input logic stall, input logic flush);
    if (flush) return PC_FLUSH;
    if (stall) return PC_STALL;
    return PC_NORMAL;
  endfunction

endpackage

// File: rtl/if_id_stage_program_counter.sv
// Program counter register with the +4 adder and redirect alignment.
// Reset is synchronous and overrides every other request.
module program_counter
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  pc_op_e      op_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pcPlus4;

  assign pcPlus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    unique case (op_i)
      PC_FLUSH:  pc_d = target_i & 32'hFFFF_FFFC;
      PC_STALL:  pc_d = pc_q;
      default:   pc_d = pcPlus4;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pcPlus4;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register with decode field
// slicing and debug fetch/stall counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_pc,
  input  logic [31:0] io_instruction,
  input  logic        io_stall,
  input  logic        io_flush,
  input  logic [31:0] io_branch_target,
  output logic        io_if_id_valid,
  output logic [31:0] io_if_id_pc_plus4,
  output logic [31:0] io_if_id_instruction,
  output logic [5:0]  io_opcode,
  output logic [4:0]  io_rs,
  output logic [4:0]  io_rt,
  output logic [4:0]  io_rd,
  output logic [4:0]  io_shamt,
  output logic [5:0]  io_funct,
  output logic [15:0] io_immidiate,
  output logic [25:0] io_jump_address,
  output logic [31:0] io_fetch_count,
  output logic [31:0] io_stall_count
);

  pc_op_e      pcOp;
  logic [31:0] pcPlus4Next;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic [31:0] stallCount_q, stallCount_d;

  assign pcOp = pcOpSelect(io_stall, io_flush);

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .op_i       (pcOp),
    .target_i   (io_branch_target),
    .pc_o       (io_pc),
    .pc_plus4_o (pcPlus4Next)
  );

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pcPlus4_d    = pcPlus4_q;
    fetchCount_d = fetchCount_q;
    stallCount_d = stallCount_q;
    unique case (pcOp)
      PC_FLUSH: begin
        valid_d   = 1'b0;
        instr_d   = NOP_INSTR;
        pcPlus4_d = 32'd0;
      end
      PC_STALL: begin
        stallCount_d = stallCount_q + 32'd1;
      end
      default: begin
        valid_d      = 1'b1;
        instr_d      = io_instruction;
        pcPlus4_d    = pcPlus4Next;
        fetchCount_d = fetchCount_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pcPlus4_q    <= 32'd0;
      fetchCount_q <= 32'd0;
      stallCount_q <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pcPlus4_q    <= pcPlus4_d;
      fetchCount_q <= fetchCount_d;
      stallCount_q <= stallCount_d;
    end
  end

  // Decode fields come only from the registered word, never from the ROM.
  assign io_if_id_valid       = valid_q;
  assign io_if_id_pc_plus4    = pcPlus4_q;
  assign io_if_id_instruction = instr_q;
  assign io_opcode            = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign io_rs                = instr_q[RS_MSB:RS_LSB];
  assign io_rt                = instr_q[RT_MSB:RT_LSB];
  assign io_rd                = instr_q[RD_MSB:RD_LSB];
  assign io_shamt             = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign io_funct             = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign io_immidiate         = instr_q[IMM_MSB:IMM_LSB];
  assign io_jump_address      = instr_q[JADDR_MSB:JADDR_LSB];
  assign io_fetch_count       = fetchCount_q;
  assign io_stall_count       = stallCount_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized self-checking bench for if_id_stage against a cycle-level
// behavioural model, plus directed literal checks including PC wraparound.
module tb_if_id_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] target;

  logic [31:0] rom [0:255];
  logic [31:0] romData;

  logic [31:0] pc, ifPc4, ifInstr, fetchCnt, stallCnt;
  logic        ifValid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  logic [31:0] wPc, wPc4, wInstr, wFetch, wStall;
  logic        wValid;
  logic [5:0]  wOpcode, wFunct;
  logic [4:0]  wRs, wRt, wRd, wShamt;
  logic [15:0] wImm;
  logic [25:0] wJaddr;

  int testsRun = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  logic [31:0] mPc, mInstr, mPc4, mFetch, mStall;
  logic        mValid;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign romData = rom[pc[9:2]];

  if_id_stage dut (
    .clock(clock), .reset(reset), .io_pc(pc), .io_instruction(romData),
    .io_stall(stall), .io_flush(flush), .io_branch_target(target),
    .io_if_id_valid(ifValid), .io_if_id_pc_plus4(ifPc4),
    .io_if_id_instruction(ifInstr), .io_opcode(opcode), .io_rs(rs),
    .io_rt(rt), .io_rd(rd), .io_shamt(shamt), .io_funct(funct),
    .io_immidiate(imm), .io_jump_address(jaddr),
    .io_fetch_count(fetchCnt), .io_stall_count(stallCnt)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clock(clock), .reset(reset), .io_pc(wPc), .io_instruction(wPc),
    .io_stall(1'b0), .io_flush(1'b0), .io_branch_target(32'h0),
    .io_if_id_valid(wValid), .io_if_id_pc_plus4(wPc4),
    .io_if_id_instruction(wInstr), .io_opcode(wOpcode), .io_rs(wRs),
    .io_rt(wRt), .io_rd(wRd), .io_shamt(wShamt), .io_funct(wFunct),
    .io_immidiate(wImm), .io_jump_address(wJaddr),
    .io_fetch_count(wFetch), .io_stall_count(wStall)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic [31:0] t);
    reset  = r;
    stall  = s;
    flush  = f;
    target = t;
    @(posedge clock);
    #1;
  endtask

  // Reference model: one rule per edge, highest priority first.
  always @(posedge clock) begin
    if (reset) begin
      mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      mFetch = 32'h0; mStall = 32'h0;
    end else if (flush) begin
      mPc = {target[31:2], 2'b00};
      mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
    end else if (stall) begin
      mStall = mStall + 1;
    end else begin
      mInstr = rom[mPc[9:2]];
      mPc4   = mPc + 4;
      mPc    = mPc + 4;
      mValid = 1'b1;
      mFetch = mFetch + 1;
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("pc",       pc,       mPc);
      checkOutput("valid",    {31'h0, ifValid}, {31'h0, mValid});
      checkOutput("pcPlus4",  ifPc4,    mPc4);
      checkOutput("instr",    ifInstr,  mInstr);
      checkOutput("opcode",   {26'h0, opcode}, mInstr >> 26);
      checkOutput("rs",       {27'h0, rs},     (mInstr >> 21) & 32'h1F);
      checkOutput("rt",       {27'h0, rt},     (mInstr >> 16) & 32'h1F);
      checkOutput("rd",       {27'h0, rd},     (mInstr >> 11) & 32'h1F);
      checkOutput("shamt",    {27'h0, shamt},  (mInstr >> 6) & 32'h1F);
      checkOutput("funct",    {26'h0, funct},  mInstr & 32'h3F);
      checkOutput("imm",      {16'h0, imm},    mInstr & 32'hFFFF);
      checkOutput("jaddr",    {6'h0, jaddr},   mInstr & 32'h03FF_FFFF);
      checkOutput("fetchCnt", fetchCnt, mFetch);
      checkOutput("stallCnt", stallCnt, mStall);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = i * 4;
    rom[4] = 32'h2008_FFFF;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkEn = 1'b1;
    checkOutput("rst pc",     pc, 32'h0);
    checkOutput("rst valid",  {31'h0, ifValid}, 32'h0);
    checkOutput("rst fetch",  fetchCnt, 32'h0);
    checkOutput("wrap rst pc", wPc, 32'hFFFF_FFFC);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("run pcPlus4", ifPc4, 32'(4 * k));
      checkOutput("run imm", {16'h0, imm}, 32'(4 * (k - 1)));
      checkOutput("run pc", pc, 32'(4 * k));
      if (k == 1) begin
        checkOutput("wrap pc0", wPc, 32'h0);
        checkOutput("wrap pcPlus4", wPc4, 32'h0);
        checkOutput("wrap instr", wInstr, 32'hFFFF_FFFC);
      end
      if (k == 2) checkOutput("wrap pc4", wPc, 32'h4);
    end
    checkOutput("run fetch", fetchCnt, 32'd4);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("stall pc", pc, 32'h10);
      checkOutput("stall pcPlus4", ifPc4, 32'h10);
      checkOutput("stall instr", ifInstr, 32'h0C);
    end
    checkOutput("stall count", stallCnt, 32'd3);

    applyStimulus(0, 0, 0, 0);
    checkOutput("addi pc", pc, 32'h14);
    checkOutput("addi opcode", {26'h0, opcode}, 32'h08);
    checkOutput("addi rs", {27'h0, rs}, 32'h0);
    checkOutput("addi rt", {27'h0, rt}, 32'h8);
    checkOutput("addi imm", {16'h0, imm}, 32'hFFFF);
    checkOutput("addi valid", {31'h0, ifValid}, 32'h1);

    applyStimulus(0, 1, 1, 32'h0000_0043);
    checkOutput("flush pc", pc, 32'h40);
    checkOutput("flush valid", {31'h0, ifValid}, 32'h0);
    checkOutput("flush instr", ifInstr, 32'h0);
    checkOutput("flush stallCnt", stallCnt, 32'd3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("target instr", ifInstr, 32'h40);
    checkOutput("target pcPlus4", ifPc4, 32'h44);
    checkOutput("target fetch", fetchCnt, 32'd6);

    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 99) < 15),
                    $urandom);
    end

    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0);
    checkOutput("pre fetch", fetchCnt, 32'd5);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pre stall", stallCnt, 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mid rst pc", pc, 32'h0);
    checkOutput("mid rst valid", {31'h0, ifValid}, 32'h0);
    checkOutput("mid rst fetch", fetchCnt, 32'h0);
    checkOutput("mid rst stall", stallCnt, 32'h0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
